// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the cache base address, default fetch queue depth, cache op encodings
// and the {pc, inst} entry carried from fetch to decode.
package inst_fetch_pkg;

  // Base of the instruction region; the PC comes out of reset here.
  localparam logic [31:0] INST_CACHE_OFFSET = 32'h0000_1000;

  // Fetch queue entries; must be a power of two and at least 2.
  localparam int unsigned FETCH_QUEUE_DEPTH = 2;

  // Cache operation encodings.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Sync FIFO of fetched {pc, inst} entries with push/pop/flush.
// Latency: a pushed entry is visible on head_dat_o the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
// Ports: clk/rst (sync, active-low), flush_i empties the queue, push_i/push_dat_i
//   enqueue, pop_i dequeues the head, full_o/empty_o status, head_dat_o is the
//   head entry (all zero while empty).
module inst_fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_dat_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Full-with-pop writes into the slot being read this cycle; the head value
  // has already been consumed combinationally, so the overwrite is safe.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, reads the I-cache every cycle, queues {pc, inst} for decode.
// Latency: word at PC X appears on dec_* the cycle after X is pushed; 1 inst/cycle steady.
// Backpressure: decode stalls fill the queue, then the PC holds and is re-presented.
// Ports: clk/rst (sync, active-low), redirect_valid/redirect_pc load a new PC and
//   flush, ic_* is the cache port (address = PC, read-only tie-offs, ic_rdata
//   combinational), dec_* is the valid/ready handshake to decode, misalign is a
//   sticky flag set by an unaligned redirect target that halts fetch.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = INST_CACHE_OFFSET,
  parameter int unsigned QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ic_address,
  output logic [31:0] ic_i_val,
  output logic        ic_op_type,
  input  logic [31:0] ic_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        misalign
);

  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic         q_full;
  logic         q_empty;
  logic         pop;
  logic         push;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign ic_address = pc_q;
  assign ic_i_val   = 32'h0;
  assign ic_op_type = OP_READ;

  assign dec_valid = !q_empty;
  assign dec_pc    = head.pc;
  assign dec_inst  = head.inst;
  assign misalign  = misalign_q;

  // A redirect voids any handshake in its cycle; the queue is flushed anyway.
  assign pop  = dec_valid && dec_ready && !redirect_valid;
  assign push = !redirect_valid && !misalign_q && (!q_full || pop);

  assign push_entry.pc   = pc_q;
  assign push_entry.inst = ic_rdata;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      // Target is loaded even when unaligned; the flag gates further fetches.
      pc_d       = redirect_pc;
      misalign_d = |redirect_pc[1:0];
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  inst_fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (redirect_valid),
    .push_i    (push),
    .push_dat_i(push_entry),
    .pop_i     (pop),
    .full_o    (q_full),
    .empty_o   (q_empty),
    .head_dat_o(head)
  );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RP    = INST_CACHE_OFFSET;
  localparam int          DEPTH = FETCH_QUEUE_DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ic_address;
  logic [31:0] ic_i_val;
  logic        ic_op_type;
  logic [31:0] ic_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        misalign;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Cache contents: three preloaded words at the reset PC, a scrambled address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RP)              return 32'h13;
    if (a == RP + 32'd4)      return 32'h93;
    if (a == RP + 32'd8)      return 32'h113;
    return {a[7:0], a[31:8]} ^ 32'h0BAD_F00D;
  endfunction

  assign ic_rdata = mem_word(ic_address);

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ic_address    (ic_address),
    .ic_i_val      (ic_i_val),
    .ic_op_type    (ic_op_type),
    .ic_rdata      (ic_rdata),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .misalign      (misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of fetched words plus the PC and sticky flag.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc = '0;
  bit          mmis = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      mpc  = RP;
      mmis = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      mpc  = redirect_pc;
      mmis = (redirect_pc[1:0] != 2'b00);
    end else begin
      bit pop_m, push_m;
      ent_t e;
      pop_m  = (mq.size() > 0) && dec_ready;
      push_m = !mmis && ((mq.size() < DEPTH) || pop_m);
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        e.pc   = mpc;
        e.inst = mem_word(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dec_valid",  32'(dec_valid), 32'(mq.size() != 0));
      chk("dec_pc",     dec_pc,   (mq.size() != 0) ? mq[0].pc   : 32'h0);
      chk("dec_inst",   dec_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
      chk("ic_address", ic_address, mpc);
      chk("misalign",   32'(misalign), 32'(mmis));
      chk("ic_op_type", 32'(ic_op_type), 32'(OP_READ));
      chk("ic_i_val",   ic_i_val, 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;

    // Reset state.
    cycn(2);
    chk_en = 1'b1;
    chk("rst dec_valid", 32'(dec_valid), 32'h0);
    chk("rst ic_address", ic_address, RP);
    chk("rst misalign", 32'(misalign), 32'h0);

    // Streaming from the reset PC, one instruction per cycle.
    rst = 1'b1; dec_ready = 1'b1;
    cyc();
    chk("t1 pc0", dec_pc, RP);
    chk("t1 inst0", dec_inst, 32'h13);
    cyc();
    chk("t1 pc1", dec_pc, RP + 32'd4);
    chk("t1 inst1", dec_inst, 32'h93);
    cyc();
    chk("t1 pc2", dec_pc, RP + 32'd8);
    chk("t1 inst2", dec_inst, 32'h113);

    // Decode stall from reset: two entries queue, PC parks at RP+8.
    rst = 1'b0; cyc();
    rst = 1'b1; dec_ready = 1'b0;
    cycn(5);
    chk("t2 stall addr", ic_address, RP + 32'd8);
    chk("t2 stall head", dec_pc, RP);
    dec_ready = 1'b1;
    cyc();
    chk("t2 rel pc1", dec_pc, RP + 32'd4);
    cyc();
    chk("t2 rel pc2", dec_pc, RP + 32'd8);
    chk("t2 rel inst2", dec_inst, 32'h113);

    // Redirect while full and decode ready.
    dec_ready = 1'b0;
    cycn(3);
    redirect_valid = 1'b1; redirect_pc = RP + 32'h40; dec_ready = 1'b1;
    cyc();
    chk("t3 flush valid", 32'(dec_valid), 32'h0);
    chk("t3 redirect addr", ic_address, RP + 32'h40);
    redirect_valid = 1'b0;
    cyc();
    chk("t3 target pc", dec_pc, RP + 32'h40);

    // Misaligned redirect halts fetch until an aligned redirect.
    redirect_valid = 1'b1; redirect_pc = RP + 32'h42;
    cyc();
    redirect_valid = 1'b0;
    chk("t4 misalign set", 32'(misalign), 32'h1);
    cycn(4);
    chk("t4 halted valid", 32'(dec_valid), 32'h0);
    chk("t4 halted addr", ic_address, RP + 32'h42);
    redirect_valid = 1'b1; redirect_pc = RP + 32'h10;
    cyc();
    redirect_valid = 1'b0;
    chk("t4 misalign clr", 32'(misalign), 32'h0);
    cyc();
    chk("t4 resume pc", dec_pc, RP + 32'h10);

    // Reset mid-stream with a full queue, then reset while misaligned.
    dec_ready = 1'b0;
    cycn(3);
    rst = 1'b0;
    cyc();
    chk("t5 rst valid", 32'(dec_valid), 32'h0);
    chk("t5 rst addr", ic_address, RP);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = RP + 32'h21;
    cyc();
    redirect_valid = 1'b0; rst = 1'b0;
    cyc();
    chk("t5 rst misalign", 32'(misalign), 32'h0);

    // PC wrap at the top of the address space.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; dec_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("t6 pc top", dec_pc, 32'hFFFF_FFFC);
    cyc();
    chk("t6 pc wrap", dec_pc, 32'h0000_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = RP + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(1, 3));
        1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        default: redirect_pc = RP + 32'($urandom_range(0, 63) * 4);
      endcase
      dec_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
